// File: rtl/fetch_buffer.sv
// fetch_buffer: PC generator, sync imem fetch and in-order instruction queue.
// Define FETCH_PERF_EN to add the perf_fetched / perf_flushes counters.
module fetch_buffer #(
  parameter int PC_W     = 17,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 32768
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-3:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushes
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] infl_pc_q;
  logic            inflight_q;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PC_W-1:0] pc_mem_q  [DEPTH];
  logic [31:0]     ins_mem_q [DEPTH];

  logic          issue;
  logic          enq;
  logic          deq;
  logic [OW-1:0] occ;
  logic          unused_rpc;

  assign unused_rpc = ^redirect_pc[1:0];

  // Occupancy counts reserved slots so an issue can never overflow.
  assign occ   = {1'b0, count_q} + OW'(inflight_q);
  assign issue = !redirect && (occ < DEPTH_C);
  assign enq   = inflight_q && !redirect;
  assign deq   = out_valid && out_ready && !redirect;

  assign imem_addr = fetch_pc_q[PC_W-1:2];
  assign out_valid = (count_q != '0);
  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign out_instr = ins_mem_q[rd_ptr_q];

  // Next fetch PC: redirect target, sequential advance or hold.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect)
      fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
    else if (issue)
      fetch_pc_d = fetch_pc_q + PC_W'(4);
  end

  // Queue occupancy update.
  always_comb begin
    count_d = count_q;
    if (redirect) begin
      count_d = '0;
    end else begin
      unique case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Fetch PC, inflight tracking, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= PC_W'(RESET_PC);
      infl_pc_q  <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      inflight_q <= issue;
      if (issue)
        infl_pc_q <= fetch_pc_q;
      if (redirect) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (enq)
          wr_ptr_q <= wr_ptr_q + PW'(1);
        if (deq)
          rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  // Queue storage; cleared on reset so the head reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else if (enq) begin
      pc_mem_q[wr_ptr_q]  <= infl_pc_q;
      ins_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_flushes_q;

  assign perf_fetched = perf_fetched_q;
  assign perf_flushes = perf_flushes_q;

  // Dequeue and redirect event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (deq)
        perf_fetched_q <= perf_fetched_q + 32'd1;
      if (redirect)
        perf_flushes_q <= perf_flushes_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: random + directed stimulus, queue scoreboard on fetch_buffer.
// Memory word n holds n; expected PCs form a contiguous stream per restart.
module tb_fetch_buffer;

  localparam logic [16:0] RST_PC = 17'h08000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [16:0] redirect_pc = '0;
  logic [14:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [16:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushes;
  logic [31:0] m_fetched = 0, m_flushes = 0;
`endif

  fetch_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushes(perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= {17'd0, imem_addr};

  int passed = 0;
  int total  = 0;
  int n_deq  = 0;
  int since  = 0;
  logic [16:0] start = RST_PC;
  logic [16:0] exp_q[$];
  logic [16:0] pred;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back(pred);
      pred = pred + 17'd4;
    end
  endtask

  task automatic restart(input logic [16:0] s);
    exp_q.delete();
    pred = {s[16:2], 2'b00};
    topup();
  endtask

  task automatic cyc(input logic rst_n, input logic rd,
                     input logic [16:0] rpc, input logic rdy);
    reset       = rst_n;
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
    if (!rst_n) restart(RST_PC);
    else if (rd) restart(rpc);
    else topup();
    @(posedge clk);
    #1;
  endtask

  // Monitor: timing rules and in-order delivery against the queue.
  always @(negedge clk) begin
    logic [16:0] e;
    if (!reset) begin
      since = 0;
      start = RST_PC;
      check("rst_valid", out_valid, 0);
      check("rst_pc", out_pc, 0);
      check("rst_instr", out_instr, 0);
`ifdef FETCH_PERF_EN
      m_fetched = 0;
      m_flushes = 0;
      check("rst_perf_f", perf_fetched, 0);
      check("rst_perf_r", perf_flushes, 0);
`endif
    end else begin
`ifdef FETCH_PERF_EN
      check("perf_fetched", perf_fetched, m_fetched);
      check("perf_flushes", perf_flushes, m_flushes);
`endif
      if (redirect) begin
        since = 0;
        start = {redirect_pc[16:2], 2'b00};
`ifdef FETCH_PERF_EN
        m_flushes++;
`endif
      end else begin
        since++;
        check("valid_timing", out_valid, since >= 3);
        if (since == 1)
          check("restart_addr", imem_addr, {17'd0, start[16:2]});
        if (out_valid && out_ready) begin
          n_deq++;
`ifdef FETCH_PERF_EN
          m_fetched++;
`endif
          if (exp_q.size() == 0) begin
            check("queue_nonempty", 0, 1);
          end else begin
            e = exp_q.pop_front();
            check("out_pc", out_pc, e);
            check("out_instr", out_instr, {17'd0, e[16:2]});
          end
        end
      end
    end
  end

  initial begin
    int r;
    restart(RST_PC);
    repeat (3) cyc(0, 0, 0, 1);
    repeat (12) cyc(1, 0, 0, 1);
    // Stall with a fresh stream: four issues then fetch stops.
    repeat (2) cyc(0, 0, 0, 0);
    repeat (10) cyc(1, 0, 0, 0);
    check("stall_fetch_pc", imem_addr, 15'h2004);
    repeat (12) cyc(1, 0, 0, 1);
    // Redirect into a full queue while decode is accepting.
    repeat (6) cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    cyc(1, 1, 17'h00123, 1);
    repeat (10) cyc(1, 0, 0, 1);
    // PC wrap at the top of the address space.
    cyc(1, 1, 17'h1FFFC, 1);
    repeat (10) cyc(1, 0, 0, 1);
    // One-cycle reset pulse with entries queued.
    repeat (5) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    repeat (12) cyc(1, 0, 0, 1);
    // Back-to-back redirects: last one wins.
    cyc(1, 1, 17'h00400, 1);
    cyc(1, 1, 17'h00800, 1);
    repeat (8) cyc(1, 0, 0, 1);
    repeat (3000) begin
      r = $urandom_range(0, 299);
      cyc(r != 0, (r >= 1) && (r <= 8), 17'($urandom),
          $urandom_range(0, 3) != 0);
    end
    cyc(1, 0, 0, 1);
    check("deliveries", n_deq > 500, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 The block SHALL have parameter PC_W, default 17, meaning byte-address PC width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of two, 2..16).
REQ-003 The block SHALL have parameter RESET_PC, default 32768, meaning first fetch byte address.
REQ-004 The block SHALL have port clk, input, 1 bit, the clock.
REQ-005 The block SHALL have port reset, input, 1 bit, reset, asynchronous, active-low.
REQ-006 The block SHALL have port redirect, input, 1 bit, flush and restart fetch.
REQ-007 The block SHALL have port redirect_pc, input, PC_W bits, restart byte address.
REQ-008 The block SHALL have port imem_addr, output, PC_W-2 bits, word address to synchronous instruction memory.
REQ-009 The block SHALL have port imem_rdata, input, 32 bits, memory data, valid one cycle after address.
REQ-010 The block SHALL have port out_valid, output, 1 bit, queue head valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit, decode accepts head.
REQ-012 The block SHALL have port out_pc, output, PC_W bits, head byte address.
REQ-013 The block SHALL have port out_instr, output, 32 bits, head instruction.

Function
REQ-014 The block SHALL issue one fetch per cycle at fetch PC whenever (count + inflight) < DEPTH and redirect is low; an issue sets inflight for exactly one cycle and advances fetch PC by 4, modulo 2^PC_W.
REQ-015 The block SHALL drive imem_addr = fetch_pc[PC_W-1:2] every cycle, issued or not.
REQ-016 The block SHALL enqueue imem_rdata with its issuing PC in the cycle after an issue, unless that response is killed.
REQ-017 The block SHALL drive out_valid = (count != 0), with out_pc and out_instr taken from the queue head registers and no combinational path from imem_rdata.
REQ-018 The block SHALL dequeue the head when out_valid & out_ready are both high.
REQ-019 The block SHALL allow enqueue and dequeue in the same cycle, with count unchanged; reservation via inflight guarantees no overflow at full.
REQ-020 On redirect high, the block SHALL clear count and pointers, kill any inflight response, ignore a simultaneous dequeue, and set fetch_pc = {redirect_pc[PC_W-1:2], 2'b00}; the first fetch from the new PC SHALL issue in the following cycle.
REQ-021 The block SHALL never emit an instruction fetched before a redirect after that redirect.
REQ-022 Back-to-back redirects SHALL each take effect; the last one wins.
REQ-023 With continuous out_ready, steady state SHALL deliver one instruction per cycle, with first out_valid two cycles after reset release or redirect.

Reset
REQ-024 While reset is low, the block SHALL hold fetch_pc = RESET_PC, count = 0, inflight = 0, pointers = 0, out_valid = 0, out_pc = 0, and out_instr = 0.
REQ-025 Reset asserted mid-operation SHALL discard all queued and inflight instructions immediately; the first issue after release SHALL be at RESET_PC.

Configuration
REQ-026 With macro FETCH_PERF_EN defined, the block SHALL add outputs perf_fetched, 32 bits, counting dequeues, and perf_flushes, 32 bits, counting redirect cycles; both reset to 0, wrap at 2^32 and are registered.
REQ-027 Without FETCH_PERF_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 Reset release with out_ready=1 and memory word n = n -> out_pc 0x8000, 0x8004, 0x8008 on consecutive cycles, the first out_valid on the 2nd cycle after release.
REQ-029 Scenario: out_ready=0 for 10 cycles -> count saturates at 4, imem issues stop after 4, fetch_pc = 0x8010; out_ready=1 -> 0x8000..0x800C then 0x8010 with no gap or duplicate.
REQ-030 Scenario: redirect with redirect_pc=0x0123 while queue is full and a fetch is inflight -> next cycle out_valid=0, imem_addr=0x48; first out_pc=0x0120, and no stale PC appears.
REQ-031 Scenario: redirect, out_valid and out_ready all high in one cycle -> no dequeue counted (perf_fetched unchanged), perf_flushes increments by 1.
REQ-032 Scenario: fetch_pc=0x1FFFC with PC_W=17 -> the next out_pc is 0x00000 (wrap).
REQ-033 Scenario: reset pulsed low for 1 cycle with 3 entries queued -> out_valid=0 immediately, and after release out_pc restarts at 0x8000.
